regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug read-out engine for the 32×32 register file. On a start request it walks a contiguous (wrapping) range of register indices, drives each index onto one combinational register-file read port, and streams the `{index, value}` pairs out over a valid/ready handshake. It sits beside the single-cycle datapath and owns the debug read port while busy. It is the reader counterpart of the register-file write path.

## Interface
Parameters:
- `SKIP_ZERO`, default 0: when 1, index 0 is never emitted. It is hard-wired zero.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a dump; sampled only in IDLE.
- `abort` in 1: cancel the dump in progress.
- `first_idx` in 5: first register index; latched on accepted start.
- `last_idx` in 5: last register index; latched on accepted start.
- `rd_addr` out 5: to register-file read address.
- `rd_data` in 32: from register-file read data, combinational from `rd_addr`.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: consumer accepts the word.
- `out_idx` out 5: index of the presented word.
- `out_data` out 32: value of the presented word.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the range completes normally.

## Operation
State machine: IDLE, LOAD, SEND, DONE.
- **IDLE**
  - `start=1` and `abort=0`: latch `cur<=first_idx`, `last<=last_idx`, go to LOAD.
  - `abort` has priority over `start`.
- **LOAD**
  - `rd_addr=cur`. Capture `out_data<=rd_data` and `out_idx<=cur`, then go to SEND.
  - If `SKIP_ZERO=1` and `cur==0`:
    - If `cur==last`, go to DONE and emit nothing.
    - Otherwise `cur<=cur+1` and stay in LOAD.
- **SEND**
  - `out_valid=1`. `out_idx` and `out_data` are held stable until the handshake.
  - On `out_ready=1`:
    - If `cur==last`, go to DONE.
    - Otherwise `cur<=cur+1` (mod 32) and go to LOAD.
- **DONE**: `done=1` for exactly one cycle, then IDLE.
- **Abort**: `abort=1` in LOAD, SEND or DONE forces IDLE on the next edge.
  - No `done` pulse.
  - `out_valid` drops that edge. A word whose handshake coincides with `abort` counts as transferred.
- **Range arithmetic**
  - The index increments modulo 32, so 31 wraps to 0.
  - Word count is `((last_idx-first_idx) mod 32)+1`.
  - `first==last` gives 1 word. `last==first-1` gives all 32 words.
  - With `SKIP_ZERO=1`, subtract 1 if index 0 lies in the range.
- `start` while busy is ignored; the latched range is unaffected.
- `rd_addr` always equals `cur`. Its value in IDLE is don't-care but must be stable; drive 0 after reset.
- Register-file writes during a dump are permitted. Each word reflects the register value at its LOAD cycle.

## Timing
- Reset (async assert, sync deassert handled upstream): state=IDLE, `cur=0`, `rd_addr=0`, `out_valid=0`, `out_idx=0`, `out_data=0`, `busy=0`, `done=0`.
- `start` accepted at edge N:
  - LOAD during cycle N+1.
  - `out_valid=1` from edge N+2.
- Throughput: at most one word per 2 cycles (LOAD+SEND) with `out_ready` held high.
- Last handshake at edge M: `done=1` during cycle M+1, `busy=0` from edge M+2.
- A new `start` is accepted in IDLE at the earliest at edge M+2.
- Each `SKIP_ZERO` skip costs 1 LOAD cycle and produces no output.
- `busy` and `done` are registered outputs.

## Test plan
- **Single word**
  - Stimulus: regs preloaded with `r[i]=0x1000_0000+i`; `start`, first=5, last=5, `out_ready=1`.
  - Response: one word `{5, 0x1000_0005}`, then a `done` pulse. `busy` is high for exactly 3 cycles.
- **Wrap**
  - Stimulus: first=30, last=1.
  - Response: indices 30, 31, 0, 1 in order, with correct data. Total 4 handshakes.
- **Back-pressure**
  - Stimulus: first=2, last=4, with `out_ready` low for 3 cycles on each word.
  - Response: `out_valid`, `out_idx` and `out_data` stay stable while stalled. Exactly 3 words are transferred, with no duplicates.
- **Full dump**
  - Stimulus: first=7, last=6.
  - Response: 32 words.
  - Repeat with `SKIP_ZERO=1`: 31 words and index 0 absent. Range 0..0 gives `done` with no words.
- **Abort**
  - Stimulus: `abort` in SEND for index 3 of range 0..10.
  - Response: IDLE next edge, no `done`, `out_valid=0`.
  - `start` and `abort` together in IDLE: no dump starts.
- **Async reset**
  - Stimulus: `rst_n` low mid-SEND.
  - Response: all outputs go to reset values immediately, without waiting for a clock edge. After release, a new `start` works normally.

Source files
------------

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks a wrapping index range of the 32x32 register
// file through one combinational read port and streams {index, value} pairs
// over a valid/ready handshake.
`timescale 1ns/1ps

module regfile_dump #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  first_idx,
    input  logic [4:0]  last_idx,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             nextState;
    logic [IDX_W-1:0]   curIdx;
    logic [IDX_W-1:0]   lastIdx;
    logic [DATA_W-1:0]  dataReg;
    logic [IDX_W-1:0]   idxReg;
    logic               validNext;
    logic               busyNext;
    logic               doneNext;
    logic               skipHit;
    logic               atLast;

    // Index 0 is hard-wired zero; with SKIP_ZERO it is stepped over in LOAD.
    assign skipHit = SKIP_ZERO && (curIdx == IDX_W'(0));
    assign atLast  = (curIdx == lastIdx);

    // State register plus the registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nextState;
            out_valid <= validNext;
            busy      <= busyNext;
            done      <= doneNext;
        end
    end

    // Next-state logic; abort wins over everything, including start in IDLE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start && !abort) nextState = LOAD;
            end
            LOAD: begin
                if (abort)                nextState = IDLE;
                else if (skipHit && atLast) nextState = DONE;
                else if (skipHit)         nextState = LOAD;
                else                      nextState = SEND;
            end
            SEND: begin
                if (abort)                nextState = IDLE;
                else if (out_ready && atLast) nextState = DONE;
                else if (out_ready)       nextState = LOAD;
                else                      nextState = SEND;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the flops line up with the state.
    always_comb begin
        validNext = 1'b0;
        busyNext  = 1'b0;
        doneNext  = 1'b0;
        if (nextState == SEND) validNext = 1'b1;
        if (nextState != IDLE) busyNext  = 1'b1;
        if (nextState == DONE) doneNext  = 1'b1;
    end

    // Range pointer and captured output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curIdx  <= '0;
            lastIdx <= '0;
            idxReg  <= '0;
            dataReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        curIdx  <= first_idx;
                        lastIdx <= last_idx;
                    end
                end
                LOAD: begin
                    if (!abort) begin
                        if (skipHit) begin
                            if (!atLast) curIdx <= curIdx + IDX_W'(1);
                        end else begin
                            idxReg  <= curIdx;
                            dataReg <= rd_data;
                        end
                    end
                end
                SEND: begin
                    if (!abort && out_ready && !atLast) curIdx <= curIdx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_addr  = curIdx;
    assign out_idx  = idxReg;
    assign out_data = dataReg;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: one instance with SKIP_ZERO=0, one with 1,
// each reading its own model register file r[i] = 0x1000_0000 + i.
`timescale 1ns/1ps

module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  firstIdx = '0;
    logic [4:0]  lastIdx = '0;
    logic        outReady = 1'b0;
    logic [4:0]  rdAddr0, rdAddr1, outIdx0, outIdx1;
    logic [31:0] rdData0, rdData1, outData0, outData1;
    logic        outValid0, outValid1, busy0, busy1, done0, done1;

    logic [31:0] rf [32];

    int checks = 0;
    int failures = 0;

    logic [4:0]  gotIdx [$];
    logic [31:0] gotData [$];
    int doneCnt, busyCnt, firstValid;

    always #5 clk = ~clk;

    assign rdData0 = rf[rdAddr0];
    assign rdData1 = rf[rdAddr1];

    regfile_dump #(.SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
        .first_idx(firstIdx), .last_idx(lastIdx), .rd_addr(rdAddr0), .rd_data(rdData0),
        .out_valid(outValid0), .out_ready(outReady), .out_idx(outIdx0), .out_data(outData0),
        .busy(busy0), .done(done0)
    );

    regfile_dump #(.SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
        .first_idx(firstIdx), .last_idx(lastIdx), .rd_addr(rdAddr1), .rd_data(rdData1),
        .out_valid(outValid1), .out_ready(outReady), .out_idx(outIdx1), .out_data(outData1),
        .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one dump on the chosen instance and record every handshake.
    task automatic runDump(input int inst, input logic [4:0] f, input logic [4:0] l,
                           input int stall, input int abortAt, input bit glitch);
        logic v, b, d;
        logic [4:0]  oi, holdIdx;
        logic [31:0] od, holdData;
        int cyc, stallCnt;
        bit aborted, holding;
        gotIdx.delete();
        gotData.delete();
        doneCnt = 0; busyCnt = 0; firstValid = -1;
        cyc = 0; stallCnt = 0; aborted = 0; holding = 0;
        holdIdx = '0; holdData = '0;
        @(negedge clk);
        firstIdx = f; lastIdx = l; outReady = 1'b0;
        if (inst == 1) start1 = 1'b1; else start0 = 1'b1;
        forever begin
            @(negedge clk);
            start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
            if (glitch && cyc == 2) begin
                if (inst == 1) start1 = 1'b1; else start0 = 1'b1;
                firstIdx = 5'd0; lastIdx = 5'd0;
            end
            v  = (inst == 1) ? outValid1 : outValid0;
            b  = (inst == 1) ? busy1 : busy0;
            d  = (inst == 1) ? done1 : done0;
            oi = (inst == 1) ? outIdx1 : outIdx0;
            od = (inst == 1) ? outData1 : outData0;
            if (aborted) begin
                chk("abort_busy", 64'(b), 64'd0);
                chk("abort_valid", 64'(v), 64'd0);
            end
            if (!b) break;
            busyCnt++;
            if (d) doneCnt++;
            outReady = 1'b0;
            if (v) begin
                if (firstValid < 0) firstValid = cyc;
                if (holding) begin
                    chk("stall_idx", 64'(oi), 64'(holdIdx));
                    chk("stall_data", 64'(od), 64'(holdData));
                end
                if (abortAt >= 0 && int'(oi) == abortAt && !aborted) begin
                    abort = 1'b1;
                    aborted = 1;
                end else if (stallCnt >= stall) begin
                    outReady = 1'b1;
                    gotIdx.push_back(oi);
                    gotData.push_back(od);
                    stallCnt = 0;
                    holding = 0;
                end else begin
                    stallCnt++;
                    holding = 1;
                    holdIdx = oi;
                    holdData = od;
                end
            end
            cyc++;
            if (cyc > 500) begin
                chk("timeout_cycles", 64'(cyc), 64'd500);
                break;
            end
        end
        outReady = 1'b0;
        start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
    endtask

    // Compare recorded words with the range walked by the reference model.
    task automatic checkWords(input string tag, input logic [4:0] f, input logic [4:0] l,
                              input bit skip);
        logic [4:0] idx;
        logic [4:0] expIdx [$];
        idx = f;
        forever begin
            if (!(skip && idx == 5'd0)) expIdx.push_back(idx);
            if (idx == l) break;
            idx = idx + 5'd1;
        end
        chk({tag, "_count"}, 64'(gotIdx.size()), 64'(expIdx.size()));
        for (int i = 0; i < expIdx.size() && i < gotIdx.size(); i++) begin
            chk({tag, "_idx"}, 64'(gotIdx[i]), 64'(expIdx[i]));
            chk({tag, "_data"}, 64'(gotData[i]), 64'(32'h1000_0000 + 32'(expIdx[i])));
        end
    endtask

    initial begin
        int zeros;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        chk("rst_rd_addr", 64'(rdAddr0), 64'd0);
        chk("rst_valid", 64'(outValid0), 64'd0);
        chk("rst_idx", 64'(outIdx0), 64'd0);
        chk("rst_data", 64'(outData0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single word: LOAD, SEND, DONE.
        runDump(0, 5'd5, 5'd5, 0, -1, 1'b0);
        checkWords("single", 5'd5, 5'd5, 1'b0);
        chk("single_done", 64'(doneCnt), 64'd1);
        chk("single_busy", 64'(busyCnt), 64'd3);
        chk("single_latency", 64'(firstValid), 64'd1);

        // Wrap 30..1 with an ignored start pulse while busy.
        runDump(0, 5'd30, 5'd1, 0, -1, 1'b1);
        checkWords("wrap", 5'd30, 5'd1, 1'b0);
        chk("wrap_done", 64'(doneCnt), 64'd1);
        chk("wrap_busy", 64'(busyCnt), 64'd9);

        // Back-pressure: three stall cycles per word.
        runDump(0, 5'd2, 5'd4, 3, -1, 1'b0);
        checkWords("stall", 5'd2, 5'd4, 1'b0);
        chk("stall_done", 64'(doneCnt), 64'd1);

        // Full dump, all 32 words.
        runDump(0, 5'd7, 5'd6, 0, -1, 1'b0);
        checkWords("full", 5'd7, 5'd6, 1'b0);
        chk("full_busy", 64'(busyCnt), 64'd65);

        // Full dump with index 0 skipped: 31 words.
        runDump(1, 5'd7, 5'd6, 0, -1, 1'b0);
        checkWords("skip", 5'd7, 5'd6, 1'b1);
        zeros = 0;
        foreach (gotIdx[i]) if (gotIdx[i] == 5'd0) zeros++;
        chk("skip_no_zero", 64'(zeros), 64'd0);
        chk("skip_busy", 64'(busyCnt), 64'd64);

        // Range 0..0 with skip: done, no words.
        runDump(1, 5'd0, 5'd0, 0, -1, 1'b0);
        chk("zero_words", 64'(gotIdx.size()), 64'd0);
        chk("zero_done", 64'(doneCnt), 64'd1);
        chk("zero_busy", 64'(busyCnt), 64'd2);

        // Abort while presenting index 3 of 0..10.
        runDump(0, 5'd0, 5'd10, 0, 3, 1'b0);
        checkWords("abort", 5'd0, 5'd2, 1'b0);
        chk("abort_no_done", 64'(doneCnt), 64'd0);

        // start together with abort in IDLE starts nothing.
        @(negedge clk);
        firstIdx = 5'd1; lastIdx = 5'd2; start0 = 1'b1; abort = 1'b1;
        @(negedge clk);
        start0 = 1'b0; abort = 1'b0;
        chk("startabort_busy", 64'(busy0), 64'd0);
        @(negedge clk);
        chk("startabort_busy2", 64'(busy0), 64'd0);
        chk("startabort_valid", 64'(outValid0), 64'd0);

        // Async reset mid-SEND, then a normal dump.
        @(negedge clk);
        firstIdx = 5'd0; lastIdx = 5'd10; outReady = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (outValid0) break;
            @(negedge clk);
        end
        chk("arst_pre_valid", 64'(outValid0), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(outValid0), 64'd0);
        chk("arst_busy", 64'(busy0), 64'd0);
        chk("arst_done", 64'(done0), 64'd0);
        chk("arst_idx", 64'(outIdx0), 64'd0);
        chk("arst_data", 64'(outData0), 64'd0);
        chk("arst_rd_addr", 64'(rdAddr0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runDump(0, 5'd9, 5'd9, 0, -1, 1'b0);
        checkWords("post_rst", 5'd9, 5'd9, 1'b0);
        chk("post_rst_done", 64'(doneCnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
